// File: rtl/axis_test_pkg.sv
// Shared types and constants for the AXIS test helper blocks (sources, drains, checkers).
package axis_test_pkg;

  typedef enum logic [1:0] {
    READY_ALWAYS   = 2'd0,
    READY_LFSR     = 2'd1,
    READY_PERIODIC = 2'd2
  } ready_mode_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DONE    = 2'd1,
    TIMEOUT = 2'd2
  } drain_state_t;

  localparam logic [15:0] LFSR16_MASK = 16'hB400;

endpackage

// File: rtl/axis_ready_pattern.sv
// Backpressure pattern generator: Galois LFSR plus periodic phase counter.
// Both advance only on step; ready_next is the pattern value for the post-step state.
module axis_ready_pattern
  import axis_test_pkg::*;
#(
  parameter int unsigned READY_MODE      = 0,
  parameter int unsigned READY_THRESHOLD = 8,
  parameter int unsigned PERIOD_ON       = 3,
  parameter int unsigned PERIOD_OFF      = 2,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  output logic ready_next
);

  localparam int unsigned PERIOD = PERIOD_ON + PERIOD_OFF;
  localparam ready_mode_t MODE   = ready_mode_t'(READY_MODE[1:0]);

  logic [15:0] lfsr_q, lfsr_next;
  logic [31:0] phase_q, phase_next;

  always_comb begin
    lfsr_next  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR16_MASK : 16'h0000);
    phase_next = (phase_q == PERIOD - 1) ? '0 : phase_q + 32'd1;
    ready_next = 1'b1;
    case (MODE)
      READY_LFSR:     ready_next = {28'd0, lfsr_next[3:0]} < READY_THRESHOLD;
      READY_PERIODIC: ready_next = phase_next < PERIOD_ON;
      default:        ready_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q  <= LFSR_SEED;
      phase_q <= '0;
    end else if (step) begin
      lfsr_q  <= lfsr_next;
      phase_q <= phase_next;
    end
  end

endmodule

// File: rtl/helper_axis_drain.sv
// AXIS terminal sink with configurable backpressure, transfer counting,
// completion flag and stall watchdog.
module helper_axis_drain
  import axis_test_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 10,
  parameter int unsigned READY_MODE      = 0,
  parameter int unsigned READY_THRESHOLD = 8,
  parameter int unsigned PERIOD_ON       = 3,
  parameter int unsigned PERIOD_OFF      = 2,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int unsigned EXPECTED_COUNT  = 0,
  parameter int unsigned TIMEOUT         = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  input_valid,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic                  input_ready,
  output logic [31:0]           transfer_count,
  output logic [DATA_WIDTH-1:0] last_data,
  output logic                  done,
  output logic                  timeout
);

  drain_state_t          state, state_next;
  logic                  ready_q, pattern_ready, step, xfer;
  logic [31:0]           count_q, count_inc, idle_q;
  logic [DATA_WIDTH-1:0] last_q;

  assign xfer      = input_valid & ready_q;
  assign step      = (state == RUN) & enable;
  assign count_inc = (count_q == '1) ? count_q : count_q + 32'd1;

  axis_ready_pattern #(
    .READY_MODE      (READY_MODE),
    .READY_THRESHOLD (READY_THRESHOLD),
    .PERIOD_ON       (PERIOD_ON),
    .PERIOD_OFF      (PERIOD_OFF),
    .LFSR_SEED       (LFSR_SEED)
  ) u_pattern (
    .clk        (clk),
    .rst        (rst),
    .step       (step),
    .ready_next (pattern_ready)
  );

  // The package TIMEOUT state is shadowed by the watchdog parameter, hence the scoped name.
  always_comb begin
    state_next = state;
    if (state == RUN) begin
      if (xfer) begin
        if (EXPECTED_COUNT != 32'd0 && count_inc == EXPECTED_COUNT)
          state_next = DONE;
      end else if (step && TIMEOUT != 32'd0 && idle_q + 32'd1 == TIMEOUT) begin
        state_next = axis_test_pkg::TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      count_q <= '0;
      last_q  <= '0;
      idle_q  <= '0;
    end else begin
      ready_q <= step && (state_next == RUN) && pattern_ready;
      if (xfer) begin
        count_q <= count_inc;
        last_q  <= input_data;
        idle_q  <= '0;
      end else if (step) begin
        idle_q  <= idle_q + 32'd1;
      end
    end
  end

  assign input_ready    = ready_q;
  assign transfer_count = count_q;
  assign last_data      = last_q;
  assign done           = (state == DONE);
  assign timeout        = (state == axis_test_pkg::TIMEOUT);

endmodule
